mac_digit_sequencer: RTL and testbench
======================================

MAC_DIGIT_SEQUENCER -- requirements
Module: mac_digit_sequencer

Interface
REQ-001 SHALL have parameter ACC_W, default 24, accumulator width in bits; legal range 16..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  sequencer can accept an operand pair.
REQ-006 SHALL have port op_a  input  8  multiplicand, unsigned.
REQ-007 SHALL have port op_b  input  8  multiplier, unsigned.
REQ-008 SHALL have port mode  input  2  precision: 00 = 2-bit, 01 = 4-bit, 10 = 8-bit, 11 = reserved.
REQ-009 SHALL have port acc_clr  input  1  this operation starts a fresh accumulation.
REQ-010 SHALL have port out_valid  output  1  acc_out holds a completed result.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port acc_out  output  ACC_W  running accumulator value.
REQ-013 SHALL have port cfg_err  output  1  sticky flag: reserved mode was seen.

Function
REQ-014 SHALL implement the FSM states IDLE, MUL, ACC and DONE.
REQ-015 SHALL assert in_ready only in IDLE; handshake = in_valid & in_ready.
REQ-016 On handshake, SHALL latch op_a, op_b, mode and acc_clr, clear the product register, set digit indices i = j = 0, and go to MUL.
REQ-017 SHALL ignore operand bits above the selected width (mask to 2, 4 or 8 bits).
REQ-018 Mode 11 SHALL execute as 8-bit and set cfg_err on the handshake cycle.
REQ-019 In MUL, each cycle SHALL form one 2x2 partial product of a-digit i and b-digit j, and add it to the 16-bit product register shifted left by 2*(i+j).
REQ-020 The digit count N SHALL be 1, 2 or 4 for 2-, 4- or 8-bit mode; j SHALL increment each cycle, and i SHALL increment when j wraps from N-1.
REQ-021 After pair (N-1, N-1), SHALL go to ACC; MUL therefore lasts N*N cycles (1, 4 or 16).
REQ-022 In ACC (one cycle), SHALL set acc_out = (latched acc_clr ? 0 : acc_out) + zero-extended product, modulo 2^ACC_W, no saturation; then go to DONE.
REQ-023 In DONE, SHALL hold out_valid = 1 with acc_out stable until out_ready = 1, then return to IDLE on that same edge.
REQ-024 Latency SHALL be N*N + 2 cycles from the handshake edge to the out_valid assertion.
REQ-025 Back-to-back throughput SHALL be one result per N*N + 3 cycles when out_ready is held high.
REQ-026 in_valid, op_a, op_b, mode and acc_clr changes outside IDLE SHALL have no effect.
REQ-027 acc_out SHALL change only in ACC.

Reset
REQ-028 rst SHALL force IDLE, in_ready = 1, out_valid = 0, acc_out = 0, cfg_err = 0, product = 0 and indices = 0, immediately and independent of clk.
REQ-029 Reset asserted mid-MUL or mid-DONE SHALL discard the operation; no partial result SHALL appear after deassertion.
REQ-030 cfg_err SHALL be cleared only by rst.

Structure
REQ-031 Package mac_seq_pkg SHALL hold the mode encodings, the FSM state enum and the default ACC_W.
REQ-032 The 2x2 partial product SHALL be a single sub-module, digit_mult2 (2-bit a and b, 4-bit product, combinational), with one instance.
REQ-033 The sequencer SHALL use only that one multiplier instance; no wider multiply operator.

Verification
REQ-034 Mode 10, op_a = 255, op_b = 255, acc_clr = 1 -> out_valid 18 cycles after accept, acc_out = 65025.
REQ-035 Mode 01, op_a = 0xFF, op_b = 0x3F, acc_clr = 1 -> upper bits masked, acc_out = 225 after 6 cycles; mode 00, op_a = 3, op_b = 2 -> acc_out = 6 after 3 cycles.
REQ-036 Mode 10, 100 * 100 with acc_clr = 1, then 200 * 3 with acc_clr = 0 -> acc_out = 10000, then 10600.
REQ-037 ACC_W = 16, acc_out = 65025, then 255 * 255 with acc_clr = 0 -> acc_out = 64514 (wrap).
REQ-038 out_ready held low 5 cycles in DONE -> out_valid and acc_out stable, in_ready = 0, a new in_valid is ignored; then out_ready = 1 -> IDLE next cycle.
REQ-039 rst pulsed at MUL cycle 7 of an 8-bit op -> outputs at reset values at once, and no out_valid for that op; mode 11 op -> cfg_err = 1 until rst.

Source files
------------

// File: rtl/mac_digit_sequencer_pkg.sv
// mac_seq_pkg
// Shared definitions for the digit-serial MAC sequencer:
//   - precision mode encodings (mode_e)
//   - sequencer FSM state encoding (state_e)
//   - default accumulator width (ACC_W_DEF)
//   - helpers mapping a mode to its operand mask and last digit index,
//     and picking one 2-bit digit out of an 8-bit operand.
package mac_seq_pkg;

    localparam int ACC_W_DEF = 24;

    typedef enum logic [1:0] {
        MODE_2B  = 2'b00,
        MODE_4B  = 2'b01,
        MODE_8B  = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_ACC  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    // Index of the last 2-bit digit (N-1); reserved mode runs as 8-bit.
    function automatic logic [1:0] last_digit(input mode_e m);
        case (m)
            MODE_2B: last_digit = 2'd0;
            MODE_4B: last_digit = 2'd1;
            default: last_digit = 2'd3;
        endcase
    endfunction

    // Operand bits above the selected precision are forced to zero.
    function automatic logic [7:0] width_mask(input mode_e m);
        case (m)
            MODE_2B: width_mask = 8'h03;
            MODE_4B: width_mask = 8'h0F;
            default: width_mask = 8'hFF;
        endcase
    endfunction

    function automatic logic [1:0] digit_sel(input logic [7:0] v, input logic [1:0] idx);
        case (idx)
            2'd0:    digit_sel = v[1:0];
            2'd1:    digit_sel = v[3:2];
            2'd2:    digit_sel = v[5:4];
            default: digit_sel = v[7:6];
        endcase
    endfunction

endpackage

// File: rtl/mac_digit_sequencer_if.sv
// mac_digit_sequencer_if
// Operand/result handshake bundle for mac_digit_sequencer.
//   in_valid/in_ready : operand pair handshake (op_a, op_b, mode, acc_clr)
//   out_valid/out_ready : result handshake (acc_out)
//   cfg_err           : sticky reserved-mode flag
// Modports: master = operand producer / result consumer, slave = sequencer.
interface mac_digit_sequencer_if #(
    parameter int ACC_W = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       op_a;
    logic [7:0]       op_b;
    logic [1:0]       mode;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             cfg_err;

    modport master (
        output in_valid, op_a, op_b, mode, acc_clr, out_ready,
        input  in_ready, out_valid, acc_out, cfg_err
    );

    modport slave (
        input  in_valid, op_a, op_b, mode, acc_clr, out_ready,
        output in_ready, out_valid, acc_out, cfg_err
    );
endinterface

// File: rtl/mac_digit_sequencer_mult.sv
// digit_mult2
// Combinational 2x2 unsigned multiplier built from two shifted AND rows.
//   a_i : 2-bit multiplicand digit
//   b_i : 2-bit multiplier digit
//   p_o : 4-bit product (max 3*3 = 9)
module digit_mult2 (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [3:0] p_o
);
    logic [3:0] row0;
    logic [3:0] row1;

    assign row0 = {2'b00, a_i}       & {4{b_i[0]}};
    assign row1 = {1'b0, a_i, 1'b0}  & {4{b_i[1]}};
    assign p_o  = row0 + row1;
endmodule

// File: rtl/mac_digit_sequencer.sv
// mac_digit_sequencer
// Digit-serial multiply-accumulate: an accepted operand pair is multiplied
// one 2x2 digit pair per cycle through a single digit_mult2, then the
// 16-bit product is added into the ACC_W-bit running accumulator.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mac_digit_sequencer_if.slave (operand and result handshakes,
//          acc_out, cfg_err)
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | in_ready high, waiting for an operand pair
// S_MUL  | one digit pair per cycle, N*N cycles, product accumulates
// S_ACC  | single cycle: fold product into acc_out
// S_DONE | out_valid high, acc_out held until out_ready
module mac_digit_sequencer
    import mac_seq_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    mac_digit_sequencer_if.slave  bus
);

    state_e           state_q;
    logic [7:0]       a_q;
    logic [7:0]       b_q;
    logic [1:0]       last_q;
    logic             clr_q;
    logic [1:0]       i_q;
    logic [1:0]       j_q;
    logic [15:0]      prod_q;
    logic [ACC_W-1:0] acc_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             cfg_err_q;

    mode_e            in_mode;
    logic [7:0]       in_mask;
    logic [1:0]       a_dig;
    logic [1:0]       b_dig;
    logic [3:0]       pp;
    logic [2:0]       ij_sum;
    logic [3:0]       shift_amt;
    logic [15:0]      prod_d;
    logic [ACC_W-1:0] acc_d;

    assign in_mode = mode_e'(bus.mode);
    assign in_mask = width_mask(in_mode);

    assign a_dig = digit_sel(a_q, i_q);
    assign b_dig = digit_sel(b_q, j_q);

    digit_mult2 u_mult (
        .a_i (a_dig),
        .b_i (b_dig),
        .p_o (pp)
    );

    // Digit pair (i, j) carries weight 4^(i+j), i.e. a shift of 2*(i+j).
    assign ij_sum    = {1'b0, i_q} + {1'b0, j_q};
    assign shift_amt = {ij_sum, 1'b0};
    assign prod_d    = prod_q + (16'(pp) << shift_amt);

    // Wraps modulo 2^ACC_W by construction.
    assign acc_d = (clr_q ? '0 : acc_q) + ACC_W'(prod_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            last_q      <= '0;
            clr_q       <= 1'b0;
            i_q         <= '0;
            j_q         <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid alone
                    // completes the handshake here.
                    if (bus.in_valid) begin
                        a_q        <= bus.op_a & in_mask;
                        b_q        <= bus.op_b & in_mask;
                        last_q     <= last_digit(in_mode);
                        clr_q      <= bus.acc_clr;
                        prod_q     <= '0;
                        i_q        <= '0;
                        j_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_MUL;
                        if (in_mode == MODE_RSV) begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end

                S_MUL: begin
                    prod_q <= prod_d;
                    if (j_q == last_q) begin
                        j_q <= '0;
                        if (i_q == last_q) begin
                            i_q     <= '0;
                            state_q <= S_ACC;
                        end else begin
                            i_q <= i_q + 2'd1;
                        end
                    end else begin
                        j_q <= j_q + 2'd1;
                    end
                end

                S_ACC: begin
                    acc_q       <= acc_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end

                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc_q;
    assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_mac_digit_sequencer.sv
// Directed bench: two sequencers (ACC_W = 24 and ACC_W = 16) run in lockstep
// from the same stimulus so accumulator wrap shows up on the narrow one.
module tb_mac_digit_sequencer;

    logic clk = 1'b0;
    logic rst;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mac_digit_sequencer_if #(.ACC_W(24)) bus24 ();
    mac_digit_sequencer_if #(.ACC_W(16)) bus16 ();

    assign bus16.in_valid  = bus24.in_valid;
    assign bus16.op_a      = bus24.op_a;
    assign bus16.op_b      = bus24.op_b;
    assign bus16.mode      = bus24.mode;
    assign bus16.acc_clr   = bus24.acc_clr;
    assign bus16.out_ready = bus24.out_ready;

    mac_digit_sequencer #(.ACC_W(24)) u_dut24 (
        .clk (clk),
        .rst (rst),
        .bus (bus24.slave)
    );

    mac_digit_sequencer #(.ACC_W(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge with both DUTs in IDLE; returns at the negedge of
    // the first DONE cycle. Latency counts posedges from the handshake edge
    // (inclusive) to the first cycle showing out_valid.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                         input logic c, input int exp_lat, input int exp24,
                         input int exp16, input string tag);
        logic [31:0] acc_before;
        int          cnt;
        bit          changed;
        chk({tag, "_in_ready"}, 32'(bus24.in_ready), 32'd1);
        acc_before     = 32'(bus24.acc_out);
        bus24.in_valid = 1'b1;
        bus24.op_a     = a;
        bus24.op_b     = b;
        bus24.mode     = m;
        bus24.acc_clr  = c;
        @(posedge clk);
        #1;
        bus24.in_valid = 1'b0;
        bus24.op_a     = ~a;
        bus24.op_b     = ~b;
        bus24.mode     = 2'b11;
        bus24.acc_clr  = ~c;
        cnt     = 1;
        changed = 1'b0;
        @(negedge clk);
        while (!bus24.out_valid && cnt < 40) begin
            if (32'(bus24.acc_out) !== acc_before) changed = 1'b1;
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, 32'(cnt), 32'(exp_lat));
        chk({tag, "_acc_early"}, 32'(changed), 32'd0);
        chk({tag, "_acc24"}, 32'(bus24.acc_out), 32'(exp24));
        chk({tag, "_acc16"}, 32'(bus16.acc_out), 32'(exp16));
        chk({tag, "_ovalid16"}, 32'(bus16.out_valid), 32'd1);
    endtask

    // From a DONE negedge with out_ready high: one edge back to IDLE.
    task automatic to_idle(input string tag);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_idle_ready"}, 32'(bus24.in_ready), 32'd1);
        chk({tag, "_idle_ovalid"}, 32'(bus24.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst             = 1'b1;
        bus24.in_valid  = 1'b0;
        bus24.op_a      = '0;
        bus24.op_b      = '0;
        bus24.mode      = 2'b00;
        bus24.acc_clr   = 1'b0;
        bus24.out_ready = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus24.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus24.out_valid), 32'd0);
        chk("rst_acc24", 32'(bus24.acc_out), 32'd0);
        chk("rst_acc16", 32'(bus16.acc_out), 32'd0);
        chk("rst_cfg_err", 32'(bus24.cfg_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_op(8'd255, 8'd255, 2'b10, 1'b1, 18, 65025, 65025, "mul8_max");
        to_idle("mul8_max");
        do_op(8'd255, 8'd255, 2'b10, 1'b0, 18, 130050, 64514, "mul8_wrap");
        to_idle("mul8_wrap");
        do_op(8'hFF, 8'h3F, 2'b01, 1'b1, 6, 225, 225, "mul4_mask");
        to_idle("mul4_mask");
        do_op(8'd3, 8'd2, 2'b00, 1'b1, 3, 6, 6, "mul2");
        to_idle("mul2");
        do_op(8'd7, 8'd6, 2'b00, 1'b0, 3, 12, 12, "mul2_mask_acc");
        to_idle("mul2_mask_acc");
        do_op(8'd100, 8'd100, 2'b10, 1'b1, 18, 10000, 10000, "mul8_clr");
        to_idle("mul8_clr");
        do_op(8'd200, 8'd3, 2'b10, 1'b0, 18, 10600, 10600, "mul8_acc");
        to_idle("mul8_acc");
        chk("cfg_err_quiet", 32'(bus24.cfg_err), 32'd0);

        // Result held while the consumer stalls; new offers are ignored.
        bus24.out_ready = 1'b0;
        do_op(8'd10, 8'd20, 2'b10, 1'b1, 18, 200, 200, "hold");
        for (int k = 0; k < 5; k++) begin
            bus24.in_valid = 1'b1;
            bus24.op_a     = 8'hAA;
            bus24.op_b     = 8'h55;
            bus24.mode     = 2'b00;
            bus24.acc_clr  = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("hold_out_valid", 32'(bus24.out_valid), 32'd1);
            chk("hold_acc", 32'(bus24.acc_out), 32'd200);
            chk("hold_in_ready", 32'(bus24.in_ready), 32'd0);
        end
        bus24.in_valid  = 1'b0;
        bus24.out_ready = 1'b1;
        to_idle("hold_release");
        chk("hold_release_acc", 32'(bus24.acc_out), 32'd200);

        // Reset in MUL cycle 7 of an 8-bit op discards it.
        bus24.in_valid = 1'b1;
        bus24.op_a     = 8'd255;
        bus24.op_b     = 8'd255;
        bus24.mode     = 2'b10;
        bus24.acc_clr  = 1'b1;
        @(posedge clk);
        #1;
        bus24.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midmul_in_ready", 32'(bus24.in_ready), 32'd1);
        chk("midmul_out_valid", 32'(bus24.out_valid), 32'd0);
        chk("midmul_acc", 32'(bus24.acc_out), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus24.out_valid || bus16.out_valid) seen = 1'b1;
        end
        chk("midmul_no_result", 32'(seen), 32'd0);
        chk("midmul_acc_after", 32'(bus24.acc_out), 32'd0);

        // Reserved mode runs as 8-bit and latches cfg_err until reset.
        do_op(8'h90, 8'h03, 2'b11, 1'b1, 18, 432, 432, "rsv");
        chk("rsv_cfg_err", 32'(bus24.cfg_err), 32'd1);
        to_idle("rsv");
        do_op(8'd1, 8'd1, 2'b00, 1'b1, 3, 1, 1, "after_rsv");
        chk("cfg_err_sticky", 32'(bus24.cfg_err), 32'd1);
        to_idle("after_rsv");
        rst = 1'b1;
        #1;
        chk("cfg_err_cleared", 32'(bus24.cfg_err), 32'd0);
        chk("cfg_err_cleared16", 32'(bus16.cfg_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
